sram_burst_ctl: RTL and testbench
=================================

SRAM_BURST_CTL -- requirements
Module: sram_burst_ctl

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_W, default 12, SHALL set the address width; depth SHALL be 2^ADDR_W words.
REQ-003 Parameter LEN_W, default 8, SHALL set the burst-length field width; burst length SHALL be len+1 beats.
REQ-004 clk  input  1  SHALL be the single clock for all logic and the RAM.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 wr_valid, wr_ready, wr_addr[ADDR_W], wr_data[DATA_W]  in/out/in/in  SHALL form the write channel.
REQ-007 rd_cmd_valid, rd_cmd_ready, rd_cmd_addr[ADDR_W], rd_cmd_len[LEN_W]  in/out/in/in  SHALL form the read-command channel.
REQ-008 rd_data_valid, rd_data_ready, rd_data[DATA_W], rd_data_last  out/in/out/out  SHALL form the read-data channel.
REQ-009 busy  output  1  SHALL be high while a burst is active or read data is buffered.

Function
REQ-010 A transfer SHALL occur on any channel only on a rising clk edge with valid and ready both high.
REQ-011 wr_ready SHALL be high in every cycle after reset; each accepted write SHALL update RAM[wr_addr] at that edge.
REQ-012 rd_cmd_ready SHALL be high only in state RD_IDLE with an empty output buffer.
REQ-013 The read FSM SHALL have two states: RD_IDLE -> RD_BURST on command accept; RD_BURST -> RD_IDLE on the edge that issues the final beat.
REQ-014 In RD_BURST the block SHALL issue at most one RAM read per cycle, starting at rd_cmd_addr and incrementing the address modulo 2^ADDR_W (wrap from 2^ADDR_W-1 to 0).
REQ-015 RAM read latency SHALL be 1 cycle; each returned word SHALL enter a 2-entry output FIFO.
REQ-016 A read SHALL be issued only if (fifo_count - pop_this_cycle + reads_in_flight) < 2, so the FIFO never overflows.
REQ-017 With rd_data_ready held high, the first beat SHALL be valid 2 cycles after command accept and beats SHALL follow one per cycle with no bubbles.
REQ-018 rd_data and rd_data_last SHALL remain stable while rd_data_valid is high and rd_data_ready is low.
REQ-019 rd_data_last SHALL be high on exactly the final (len+1-th) beat.
REQ-020 A write and a read to the same address on the same edge SHALL return the newly written data (write-first).
REQ-021 len = 2^LEN_W-1 SHALL produce 2^LEN_W beats; len = 0 SHALL produce exactly one beat, flagged last.
REQ-022 rd_cmd_valid while not ready SHALL be held off without any effect on state.

Reset
REQ-023 While rst_n is low, wr_ready, rd_cmd_ready, rd_data_valid, rd_data_last and busy SHALL be 0 and rd_data SHALL be 0.
REQ-024 Reset asserted mid-burst SHALL abort the burst, flush the FIFO and in-flight reads, and return the FSM to RD_IDLE.
REQ-025 RAM contents SHALL NOT be cleared by reset.
REQ-026 wr_ready and rd_cmd_ready SHALL rise on the first clk edge after rst_n deasserts.

Structure
REQ-027 Default DATA_W/ADDR_W/LEN_W and the RD_IDLE=0/RD_BURST=1 state encoding SHALL reside in shared package sram_ctl_pkg.
REQ-028 Storage SHALL be a separate sub-module sram_sdp_ram: simple dual-port, one clock, registered 1-cycle read, write-first.
REQ-029 The controller SHALL contain the FSM, address/beat counters, in-flight tracking and the 2-entry FIFO.

Verification
REQ-030 Write 0xABCDABCDABCDABCD to 0 and 0xBCDABCDABCDABCDA to 1, then issue read addr 0, len 1 -> two beats with those values in order, last on beat 2, first valid 2 cycles after accept.
REQ-031 Write addr 4094 and 4095 and 0, then read addr 4094, len 2 -> values returned in the order 4094, 4095, 0 (wrap).
REQ-032 Burst len 7 with rd_data_ready toggled 1,0,0,1,... -> all 8 beats delivered once, in order, stable while stalled, no loss.
REQ-033 Same-cycle write 0x1234 to addr 9 and read-issue of addr 9 -> read returns 0x1234.
REQ-034 rst_n pulsed low at beat 3 of a len-15 burst -> outputs 0 at once, rd_cmd_ready 1 on the first edge after release, previously written data intact.
REQ-035 Command presented during an active burst -> held off until rd_cmd_ready rises, then served correctly.

Source files
------------

// File: rtl/sram_ctl_pkg.sv
// Shared defaults and read-FSM state encoding for the SRAM burst controller.
package sram_ctl_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

endpackage

// File: rtl/sram_sdp_ram.sv
// Simple dual-port RAM: one clock, registered 1-cycle read, write-first on address collision.
module sram_sdp_ram
    import sram_ctl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; a same-edge write to the read address is forwarded.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/sram_burst_ctl.sv
// SRAM burst controller: always-ready write channel, burst read commands served
// through a 2-entry output FIFO fed by a 1-cycle-latency RAM.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RD_IDLE  | no burst issuing; command accepted when FIFO and pipe empty
//   RD_BURST | issuing one RAM read per cycle while the FIFO has room
module sram_burst_ctl
    import sram_ctl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_cmd_valid,
    output logic              rd_cmd_ready,
    input  logic [ADDR_W-1:0] rd_cmd_addr,
    input  logic [LEN_W-1:0]  rd_cmd_len,
    output logic              rd_data_valid,
    input  logic              rd_data_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_last,
    output logic              busy
);

    rd_state_t         state_q, state_d;
    logic              out_of_rst_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [LEN_W-1:0]  beats_left_q;
    logic              in_flight_q;
    logic              in_flight_last_q;

    logic [DATA_W-1:0] fifo_data [2];
    logic              fifo_last [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        fifo_cnt_q;

    logic              cmd_accept, pop, issue, final_issue;
    logic [2:0]        occupancy;
    logic [DATA_W-1:0] ram_rdata;

    // Occupancy counts words already buffered plus the one still in the RAM pipe,
    // so a read is only launched when its result is guaranteed a FIFO slot.
    assign pop          = rd_data_valid && rd_data_ready;
    assign occupancy    = 3'(fifo_cnt_q) + 3'(in_flight_q) - 3'(pop);
    assign issue        = (state_q == RD_BURST) && (occupancy < 3'd2);
    assign final_issue  = issue && (beats_left_q == '0);

    assign wr_ready      = out_of_rst_q;
    assign rd_cmd_ready  = out_of_rst_q && (state_q == RD_IDLE) &&
                           (fifo_cnt_q == 2'd0) && !in_flight_q;
    assign cmd_accept    = rd_cmd_valid && rd_cmd_ready;
    assign rd_data_valid = (fifo_cnt_q != 2'd0);
    assign rd_data       = fifo_data[rd_ptr_q];
    assign rd_data_last  = rd_data_valid && fifo_last[rd_ptr_q];
    assign busy          = (state_q == RD_BURST) || (fifo_cnt_q != 2'd0) || in_flight_q;

    sram_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_valid && wr_ready),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (issue),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave the burst on the edge that issues the final beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:  if (cmd_accept)  state_d = RD_BURST;
            RD_BURST: if (final_issue) state_d = RD_IDLE;
            default:  state_d = RD_IDLE;
        endcase
    end

    // Ready flag, address counter, remaining-beat down-counter and read pipe tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_of_rst_q     <= 1'b0;
            rd_addr_q        <= '0;
            beats_left_q     <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
        end else begin
            out_of_rst_q     <= 1'b1;
            in_flight_q      <= issue;
            in_flight_last_q <= final_issue;
            if (cmd_accept) begin
                rd_addr_q    <= rd_cmd_addr;
                beats_left_q <= rd_cmd_len;
            end else if (issue) begin
                rd_addr_q    <= rd_addr_q + ADDR_W'(1);
                beats_left_q <= beats_left_q - LEN_W'(1);
            end
        end
    end

    // Two-entry output FIFO; entries are cleared on reset so rd_data reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (in_flight_q) begin
                fifo_data[wr_ptr_q] <= ram_rdata;
                fifo_last[wr_ptr_q] <= in_flight_last_q;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + 2'(in_flight_q) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_sram_burst_ctl.sv
// Bench for sram_burst_ctl: directed scenarios plus randomized bursts checked
// against a flat memory image and a queue of expected beats.
module tb_sram_burst_ctl;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_cmd_valid = 1'b0;
    logic              rd_cmd_ready;
    logic [ADDR_W-1:0] rd_cmd_addr = '0;
    logic [LEN_W-1:0]  rd_cmd_len = '0;
    logic              rd_data_valid;
    logic              rd_data_ready = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_last;
    logic              busy;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic [DATA_W-1:0] model [DEPTH];
    exp_t              exp_q [$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc = 0;
    int                beats_done = 0;
    int                rdy_mode = 0;
    int                pat_idx = 0;

    logic              mon_r;
    logic              held = 1'b0;
    logic [DATA_W-1:0] held_data;
    logic              held_last;
    exp_t              mon_e;

    sram_burst_ctl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_cmd_valid  (rd_cmd_valid),
        .rd_cmd_ready  (rd_cmd_ready),
        .rd_cmd_addr   (rd_cmd_addr),
        .rd_cmd_len    (rd_cmd_len),
        .rd_data_valid (rd_data_valid),
        .rd_data_ready (rd_data_ready),
        .rd_data       (rd_data),
        .rd_data_last  (rd_data_last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Read-data sink: outputs are sampled mid-cycle, so a beat seen with valid and
    // the chosen ready here is the beat transferred on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_valid", rd_data_valid, 1);
                chk("stall_data", rd_data, held_data);
                chk("stall_last", rd_data_last, held_last);
            end
            case (rdy_mode)
                0:       mon_r = 1'b1;
                1:       mon_r = ((pat_idx % 3) == 0);
                default: mon_r = ($urandom_range(0, 3) != 0);
            endcase
            pat_idx++;
            rd_data_ready = mon_r;
            held      = rd_data_valid && !mon_r;
            held_data = rd_data;
            held_last = rd_data_last;
            if (rd_data_valid && mon_r) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", rd_data, mon_e.data);
                    chk("beat_last", rd_data_last, mon_e.last);
                    beats_done++;
                end
            end
        end
    end

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        model[a] = d;
        wr_valid = 1'b0;
    endtask

    // Present a command until accepted; the expected burst is queued from the
    // memory image at the moment of acceptance. Returns just after the accept edge.
    task automatic issue_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, output int acc_cyc);
        bit got = 0;
        exp_t e;
        rd_cmd_addr  = a;
        rd_cmd_len   = l;
        rd_cmd_valid = 1'b1;
        for (int k = 0; k < 3000 && !got; k++) begin
            if (rd_cmd_ready) begin
                for (int i = 0; i <= int'(l); i++) begin
                    e.data = model[ADDR_W'(int'(a) + i)];
                    e.last = (i == int'(l));
                    exp_q.push_back(e);
                end
                got = 1;
            end
            @(negedge clk);
        end
        rd_cmd_valid = 1'b0;
        if (!got) chk("cmd_accept_timeout", 0, 1);
        acc_cyc = cyc;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, DATA_W'(exp_q.size()), 0);
        chk("idle_after_burst", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_cmd_ready"}, rd_cmd_ready, 0);
        chk({tag, "_valid"}, rd_data_valid, 0);
        chk({tag, "_last"}, rd_data_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_data"}, rd_data, 0);
    endtask

    initial begin
        int acc;
        int base;
        int k;

        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_init");
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst_hold");
        rst_n = 1'b1;
        #1 chk("rel_wr_ready_pre", wr_ready, 0);
        @(posedge clk);
        #1 chk("rel_wr_ready", wr_ready, 1);
        chk("rel_cmd_ready", rd_cmd_ready, 1);

        // Fill the whole array so every later read has a known value.
        @(negedge clk);
        for (int a = 0; a < DEPTH; a++) begin
            wr(ADDR_W'(a), {$urandom, $urandom});
        end

        // Two-beat burst with first-beat latency.
        rdy_mode = 0;
        wr(12'd0, 64'hABCDABCDABCDABCD);
        wr(12'd1, 64'hBCDABCDABCDABCDA);
        issue_cmd(12'd0, 8'd1, acc);
        chk("lat_accept_cycle", DATA_W'(cyc), DATA_W'(acc));
        @(negedge clk);
        chk("lat_not_yet_valid", rd_data_valid, 0);
        @(negedge clk);
        chk("lat_valid_at_2", rd_data_valid, 1);
        chk("lat_first_data", rd_data, 64'hABCDABCDABCDABCD);
        wait_drain("drain_basic");

        // Address wrap at the top of the array.
        wr(12'd4094, 64'h0000_0000_0000_0FFE);
        wr(12'd4095, 64'h0000_0000_0000_0FFF);
        wr(12'd0,    64'h0000_0000_0000_1000);
        issue_cmd(12'd4094, 8'd2, acc);
        wait_drain("drain_wrap");

        // Back-pressure with ready pattern 1,0,0,1,...
        rdy_mode = 1;
        pat_idx  = 0;
        issue_cmd(12'd100, 8'd7, acc);
        wait_drain("drain_stall");

        // Write coinciding with the read issue of the same address.
        rdy_mode = 0;
        wr(12'd9, 64'hDEAD_BEEF_0000_0009);
        model[9] = 64'h0000_0000_0000_1234;
        issue_cmd(12'd9, 8'd0, acc);
        wr_valid = 1'b1;
        wr_addr  = 12'd9;
        wr_data  = 64'h0000_0000_0000_1234;
        @(negedge clk);
        wr_valid = 1'b0;
        wait_drain("drain_wfirst");

        // Second command held off while a burst is active.
        issue_cmd(12'd200, 8'd7, acc);
        chk("holdoff_cmd_ready", rd_cmd_ready, 0);
        chk("holdoff_busy", busy, 1);
        issue_cmd(12'd300, 8'd3, acc);
        wait_drain("drain_holdoff");

        // Length extremes.
        rdy_mode = 2;
        issue_cmd(12'd4000, 8'd255, acc);
        wait_drain("drain_len_max");
        issue_cmd(12'd5, 8'd0, acc);
        wait_drain("drain_len_zero");

        // Reset in the middle of a long burst.
        rdy_mode = 0;
        base = beats_done;
        issue_cmd(12'd500, 8'd15, acc);
        k = 0;
        while (beats_done < base + 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_burst_reached", DATA_W'(beats_done >= base + 3), 1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 chk_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_mid_hold");
        rst_n = 1'b1;
        #1 chk("rst_mid_cmd_ready_pre", rd_cmd_ready, 0);
        @(posedge clk);
        #1 chk("rst_mid_cmd_ready", rd_cmd_ready, 1);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk);
        issue_cmd(12'd500, 8'd15, acc);
        wait_drain("drain_after_rst");

        // Randomized bursts, occasionally back to back.
        for (int t = 0; t < 12; t++) begin
            rdy_mode = int'($urandom_range(0, 2));
            pat_idx  = 0;
            issue_cmd(ADDR_W'($urandom), LEN_W'($urandom_range(0, 40)), acc);
            if ($urandom_range(0, 1) == 1) begin
                issue_cmd(ADDR_W'($urandom), LEN_W'($urandom_range(0, 40)), acc);
            end
            wait_drain("drain_random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
